// File: rtl/gen_pkt_from_phv_deparser.sv
// Deparser: replays buffered packet beats, swapping each 128b payload for the matching PHV lane.
// Control bits [133:128] always come from the buffered beat.
module gen_pkt_from_phv_deparser #(
  parameter int HEAD_WIDTH    = 1024,
  parameter int TAG_WIDTH     = 8,
  parameter int TAG_START_BIT = 0,
  parameter int TAG_TAIL_BIT  = 1,
  parameter int PKT_FIFO_AW   = 9,
  parameter int PHV_FIFO_AW   = 4
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_pkt_valid,
  input  logic [133:0]                    i_pkt,
  input  logic                            i_phv_valid,
  input  logic [HEAD_WIDTH+TAG_WIDTH-1:0] i_phv,
  output logic                            o_pkt_valid,
  output logic [133:0]                    o_pkt,
  output logic [1:0]                      o_err
);

  localparam int PKT_NUM = HEAD_WIDTH / 128;
  localparam int LANE_W  = (PKT_NUM > 1) ? $clog2(PKT_NUM) : 1;
  localparam int SLC_W   = HEAD_WIDTH + 2;

  typedef enum logic [1:0] {IDLE, EMIT, WAIT_PHV, PASS} state_t;
  state_t state, state_nxt;

  // Packet FIFO, first-word-fall-through
  logic [133:0]           pkt_mem [2**PKT_FIFO_AW];
  logic [PKT_FIFO_AW:0]   pkt_wr_ptr, pkt_rd_ptr;
  logic                   pkt_empty, pkt_full, pkt_wr, pkt_pop;
  logic [133:0]           pkt_head;
  logic [PKT_FIFO_AW:0]   cnt_pkt;

  assign pkt_empty = (pkt_wr_ptr == pkt_rd_ptr);
  assign pkt_full  = (pkt_wr_ptr[PKT_FIFO_AW] != pkt_rd_ptr[PKT_FIFO_AW]) &&
                     (pkt_wr_ptr[PKT_FIFO_AW-1:0] == pkt_rd_ptr[PKT_FIFO_AW-1:0]);
  assign pkt_wr    = i_pkt_valid && !pkt_full;
  assign pkt_head  = pkt_mem[pkt_rd_ptr[PKT_FIFO_AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (pkt_wr) pkt_mem[pkt_wr_ptr[PKT_FIFO_AW-1:0]] <= i_pkt;
  end

  // PHV FIFO keeps only the payload plus the tail/start flags
  logic [SLC_W-1:0]       phv_mem [2**PHV_FIFO_AW];
  logic [PHV_FIFO_AW:0]   phv_wr_ptr, phv_rd_ptr;
  logic                   phv_empty, phv_full, phv_wr, phv_pop;
  logic [SLC_W-1:0]       phv_in, phv_head;
  logic                   phv_head_start;
  logic                   unused_tag;

  assign phv_in         = {i_phv[HEAD_WIDTH+TAG_TAIL_BIT], i_phv[HEAD_WIDTH+TAG_START_BIT],
                           i_phv[HEAD_WIDTH-1:0]};
  assign unused_tag     = ^i_phv[HEAD_WIDTH +: TAG_WIDTH];
  assign phv_empty      = (phv_wr_ptr == phv_rd_ptr);
  assign phv_full       = (phv_wr_ptr[PHV_FIFO_AW] != phv_rd_ptr[PHV_FIFO_AW]) &&
                          (phv_wr_ptr[PHV_FIFO_AW-1:0] == phv_rd_ptr[PHV_FIFO_AW-1:0]);
  assign phv_wr         = i_phv_valid && !phv_full;
  assign phv_head       = phv_mem[phv_rd_ptr[PHV_FIFO_AW-1:0]];
  assign phv_head_start = phv_head[HEAD_WIDTH];

  always_ff @(posedge i_clk) begin
    if (phv_wr) phv_mem[phv_wr_ptr[PHV_FIFO_AW-1:0]] <= phv_in;
  end

  // Current slice and its lane view
  logic [HEAD_WIDTH-1:0]  slice_data;
  logic                   slice_tail;
  logic [LANE_W-1:0]      lane;
  logic [127:0]           lanes [PKT_NUM];

  for (genvar k = 0; k < PKT_NUM; k++) begin : g_lane
    assign lanes[k] = slice_data[HEAD_WIDTH-1-128*k -: 128];
  end

  always_ff @(posedge i_clk) begin
    if (phv_pop) begin
      slice_data <= phv_head[HEAD_WIDTH-1:0];
      slice_tail <= phv_head[HEAD_WIDTH+1];
    end
  end

  logic beat_tail, lane_last, cnt_nz;
  logic sub_sel, lane_clr, lane_inc, err_sync;

  assign beat_tail = pkt_head[133];
  assign lane_last = (lane == LANE_W'(PKT_NUM-1));
  assign cnt_nz    = (cnt_pkt != '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (cnt_nz && !phv_empty && phv_head_start) state_nxt = EMIT;
      EMIT:     if (!pkt_empty) begin
                  if (beat_tail)                   state_nxt = IDLE;
                  else if (lane_last && slice_tail) state_nxt = PASS;
                  else if (lane_last && phv_empty)  state_nxt = WAIT_PHV;
                end
      WAIT_PHV: if (!phv_empty) state_nxt = EMIT;
      PASS:     if (!pkt_empty && beat_tail) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pkt_pop  = 1'b0;
    phv_pop  = 1'b0;
    sub_sel  = 1'b0;
    lane_clr = 1'b0;
    lane_inc = 1'b0;
    err_sync = 1'b0;
    case (state)
      IDLE: if (cnt_nz && !phv_empty) begin
        phv_pop  = 1'b1;
        lane_clr = 1'b1;
        err_sync = !phv_head_start;
      end
      EMIT: if (!pkt_empty) begin
        pkt_pop = 1'b1;
        sub_sel = 1'b1;
        if (beat_tail) begin
          err_sync = !slice_tail;
        end else if (lane_last) begin
          if (slice_tail) begin
            err_sync = 1'b1;
          end else if (!phv_empty) begin
            // Chain straight into the next slice without a bubble
            phv_pop  = 1'b1;
            lane_clr = 1'b1;
            err_sync = phv_head_start;
          end
        end else begin
          lane_inc = 1'b1;
        end
      end
      WAIT_PHV: if (!phv_empty) begin
        phv_pop  = 1'b1;
        lane_clr = 1'b1;
        err_sync = phv_head_start;
      end
      PASS: pkt_pop = !pkt_empty;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pkt_wr_ptr  <= '0;
      pkt_rd_ptr  <= '0;
      phv_wr_ptr  <= '0;
      phv_rd_ptr  <= '0;
      cnt_pkt     <= '0;
      lane        <= '0;
      o_pkt_valid <= 1'b0;
      o_pkt       <= '0;
      o_err       <= 2'b00;
    end else begin
      if (pkt_wr)  pkt_wr_ptr <= pkt_wr_ptr + 1'b1;
      if (pkt_pop) pkt_rd_ptr <= pkt_rd_ptr + 1'b1;
      if (phv_wr)  phv_wr_ptr <= phv_wr_ptr + 1'b1;
      if (phv_pop) phv_rd_ptr <= phv_rd_ptr + 1'b1;
      case ({pkt_wr && i_pkt[133], pkt_pop && beat_tail})
        2'b10:   cnt_pkt <= cnt_pkt + 1'b1;
        2'b01:   cnt_pkt <= cnt_pkt - 1'b1;
        default: cnt_pkt <= cnt_pkt;
      endcase
      if (lane_clr)      lane <= '0;
      else if (lane_inc) lane <= lane + LANE_W'(1);
      o_pkt_valid <= pkt_pop;
      if (pkt_pop) o_pkt <= sub_sel ? {pkt_head[133:128], lanes[lane]} : pkt_head;
      o_err[0] <= o_err[0] | err_sync;
      o_err[1] <= o_err[1] | (i_pkt_valid && pkt_full) | (i_phv_valid && phv_full);
    end
  end

endmodule

// File: tb/tb_gen_pkt_from_phv_deparser.sv
// Bench for gen_pkt_from_phv_deparser: packet-order reference model plus literal pins.
module tb_gen_pkt_from_phv_deparser;
  localparam int HW = 1024;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            pkt_valid = 1'b0;
  logic [133:0]    pkt = '0;
  logic            phv_valid = 1'b0;
  logic [HW+7:0]   phv = '0;
  logic            o_pkt_valid;
  logic [133:0]    o_pkt;
  logic [1:0]      o_err;

  always #5 clk = ~clk;

  gen_pkt_from_phv_deparser dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_pkt_valid(pkt_valid), .i_pkt(pkt),
    .i_phv_valid(phv_valid), .i_phv(phv),
    .o_pkt_valid(o_pkt_valid), .o_pkt(o_pkt), .o_err(o_err)
  );

  logic [133:0]  pk_l[$], mp_q[$], exp_q[$], got_q[$];
  logic [HW+7:0] sl_l[$], ms_q[$];
  logic [1:0]    err_m;
  int errors = 0, checks = 0, cyc = 0;
  int first_cyc, last_cyc, max_gap, t_sl;

  function automatic logic [133:0] mk_beat(input int i, input int n, input logic [7:0] base);
    logic [1:0] code;
    logic [3:0] vb;
    code = (n == 1) ? 2'b11 : (i == 0) ? 2'b01 : (i == n-1) ? 2'b10 : 2'b00;
    vb   = (i == n-1) ? 4'h5 : 4'hF;
    return {code, vb, {16{8'(base + i)}}};
  endfunction

  function automatic logic [HW+7:0] mk_slice(input logic [7:0] base, input logic st, input logic tl);
    logic [HW+7:0] s;
    s = '0;
    for (int k = 0; k < 8; k++) s[HW-1-128*k -: 128] = {16{8'(base + k)}};
    s[HW]   = st;
    s[HW+1] = tl;
    return s;
  endfunction

  function automatic logic [127:0] lane_of(input logic [HW+7:0] s, input int k);
    logic [HW+7:0] t;
    t = s >> (HW - 128*(k+1));
    return t[127:0];
  endfunction

  // Walks whole packets against the slice list in order and appends the expected beats
  task automatic model_run();
    logic [HW+7:0] s;
    logic [133:0]  b;
    int lane;
    bit pass, found, done;
    foreach (pk_l[i]) mp_q.push_back(pk_l[i]);
    foreach (sl_l[i]) ms_q.push_back(sl_l[i]);
    while (mp_q.size() > 0) begin
      found = 0;
      while (!found && ms_q.size() > 0) begin
        s = ms_q.pop_front();
        if (s[HW]) found = 1;
        else       err_m[0] = 1'b1;
      end
      if (!found) return;
      lane = 0; pass = 0; done = 0;
      while (!done && mp_q.size() > 0) begin
        b = mp_q.pop_front();
        exp_q.push_back(pass ? b : {b[133:128], lane_of(s, lane)});
        if (b[133]) begin
          if (!pass && !s[HW+1]) err_m[0] = 1'b1;
          done = 1;
        end else if (!pass) begin
          if (lane == 7) begin
            if (s[HW+1]) begin
              err_m[0] = 1'b1;
              pass = 1;
            end else if (ms_q.size() == 0) begin
              return;
            end else begin
              s = ms_q.pop_front();
              if (s[HW]) err_m[0] = 1'b1;
              lane = 0;
            end
          end else begin
            lane++;
          end
        end
      end
    end
  endtask

  task automatic chk(input string nm, input logic [133:0] got, input logic [133:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Every cycle: compare any output beat against the model stream
  task automatic tick();
    logic [133:0] e;
    @(negedge clk);
    cyc++;
    if (rst_n && o_pkt_valid) begin
      if (got_q.size() == 0) first_cyc = cyc;
      else if (cyc - last_cyc > max_gap) max_gap = cyc - last_cyc;
      last_cyc = cyc;
      got_q.push_back(o_pkt);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL stream: unexpected beat %h, none expected", o_pkt);
      end else begin
        e = exp_q.pop_front();
        if (o_pkt !== e) begin
          errors++;
          $display("FAIL stream beat %0d: got %h expected %h", got_q.size()-1, o_pkt, e);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      pkt_valid = 1'b0;
      phv_valid = 1'b0;
    end
  endtask

  task automatic send_beat(input logic [133:0] b);
    tick();
    pkt_valid = 1'b1; pkt = b; phv_valid = 1'b0;
  endtask

  task automatic send_slice(input logic [HW+7:0] s);
    tick();
    phv_valid = 1'b1; phv = s; pkt_valid = 1'b0;
  endtask

  task automatic drive_pkt();
    foreach (pk_l[i]) send_beat(pk_l[i]);
  endtask

  task automatic drain();
    int budget = 300;
    while (exp_q.size() > 0 && budget > 0) begin
      idle(1);
      budget--;
    end
    if (budget == 0) begin
      checks++; errors++;
      $display("FAIL drain: %0d beats still expected after timeout, required 0", exp_q.size());
    end
    idle(6);
  endtask

  task automatic new_test();
    got_q.delete(); pk_l.delete(); sl_l.delete();
    max_gap = 0; first_cyc = 0; last_cyc = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; pkt_valid = 1'b0; phv_valid = 1'b0;
    exp_q.delete(); mp_q.delete(); ms_q.delete();
    err_m = 2'b00;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    new_test();
  endtask

  initial begin
    err_m = 2'b00;
    idle(3);
    chk("reset o_pkt_valid", 134'(o_pkt_valid), 134'd0);
    chk("reset o_pkt", o_pkt, 134'd0);
    chk("reset o_err", 134'(o_err), 134'd0);
    rst_n = 1'b1;
    idle(2);

    // 1) 4-beat packet, slice after tail
    new_test();
    for (int i = 0; i < 4; i++) pk_l.push_back(mk_beat(i, 4, 8'hA0));
    sl_l.push_back(mk_slice(8'hB0, 1'b1, 1'b1));
    model_run();
    drive_pkt();
    send_slice(sl_l[0]);
    t_sl = cyc;
    drain();
    chk("t1 count", 134'(got_q.size()), 134'd4);
    chk("t1 beat0", got_q[0], {2'b01, 4'hF, {16{8'hB0}}});
    chk("t1 beat3", got_q[3], {2'b10, 4'h5, {16{8'hB3}}});
    chk("t1 latency", 134'(first_cyc - t_sl), 134'd3);
    chk("t1 gap", 134'(max_gap), 134'd1);
    chk("t1 err model", 134'(o_err), 134'(err_m));
    chk("t1 err", 134'(o_err), 134'd0);

    // 2) 12-beat packet, two slices queued ahead
    new_test();
    for (int i = 0; i < 12; i++) pk_l.push_back(mk_beat(i, 12, 8'hA0));
    sl_l.push_back(mk_slice(8'h10, 1'b1, 1'b0));
    sl_l.push_back(mk_slice(8'h20, 1'b0, 1'b1));
    model_run();
    send_slice(sl_l[0]);
    send_slice(sl_l[1]);
    drive_pkt();
    drain();
    chk("t2 count", 134'(got_q.size()), 134'd12);
    chk("t2 no bubble", 134'(max_gap), 134'd1);
    chk("t2 beat7", got_q[7], {2'b00, 4'hF, {16{8'h17}}});
    chk("t2 beat8", got_q[8], {2'b00, 4'hF, {16{8'h20}}});
    chk("t2 err", 134'(o_err), 134'd0);

    // 3) same packet, second slice late
    new_test();
    for (int i = 0; i < 12; i++) pk_l.push_back(mk_beat(i, 12, 8'hA0));
    sl_l.push_back(mk_slice(8'h10, 1'b1, 1'b0));
    sl_l.push_back(mk_slice(8'h20, 1'b0, 1'b1));
    model_run();
    send_slice(sl_l[0]);
    drive_pkt();
    idle(20);
    send_slice(sl_l[1]);
    drain();
    chk("t3 count", 134'(got_q.size()), 134'd12);
    checks++;
    if (max_gap < 10) begin
      errors++;
      $display("FAIL t3 wait gap: got %0d cycles, required >= 10", max_gap);
    end
    chk("t3 beat11", got_q[11], {2'b10, 4'h5, {16{8'h23}}});
    chk("t3 err", 134'(o_err), 134'd0);

    // 4) slice without start bit, then a good packet
    do_reset();
    for (int i = 0; i < 4; i++) pk_l.push_back(mk_beat(i, 4, 8'hC0));
    sl_l.push_back(mk_slice(8'h30, 1'b0, 1'b0));
    sl_l.push_back(mk_slice(8'h40, 1'b1, 1'b1));
    model_run();
    send_slice(sl_l[0]);
    drive_pkt();
    send_slice(sl_l[1]);
    drain();
    chk("t4 count", 134'(got_q.size()), 134'd4);
    chk("t4 beat0", got_q[0], {2'b01, 4'hF, {16{8'h40}}});
    chk("t4 err model", 134'(o_err), 134'(err_m));
    chk("t4 err", 134'(o_err), 134'd1);

    // 5) 10-beat packet covered by a single start|tail slice
    do_reset();
    for (int i = 0; i < 10; i++) pk_l.push_back(mk_beat(i, 10, 8'hD0));
    sl_l.push_back(mk_slice(8'h50, 1'b1, 1'b1));
    model_run();
    drive_pkt();
    send_slice(sl_l[0]);
    drain();
    chk("t5 count", 134'(got_q.size()), 134'd10);
    chk("t5 beat7", got_q[7], {2'b00, 4'hF, {16{8'h57}}});
    chk("t5 beat8", got_q[8], {2'b00, 4'hF, {16{8'hD8}}});
    chk("t5 beat9", got_q[9], {2'b10, 4'h5, {16{8'hD9}}});
    chk("t5 err", 134'(o_err), 134'd1);

    // 6) overflow the packet FIFO, then reset in the middle of EMIT
    do_reset();
    for (int i = 0; i < 513; i++) send_beat(mk_beat(i, 600, 8'h00));
    idle(5);
    chk("t6 overflow err", 134'(o_err), 134'd2);
    chk("t6 no output", 134'(got_q.size()), 134'd0);
    do_reset();
    chk("t6 err after reset", 134'(o_err), 134'd0);
    for (int i = 0; i < 12; i++) pk_l.push_back(mk_beat(i, 12, 8'hE0));
    sl_l.push_back(mk_slice(8'h60, 1'b1, 1'b0));
    model_run();
    send_slice(sl_l[0]);
    drive_pkt();
    begin
      int budget = 50;
      while (got_q.size() < 3 && budget > 0) begin
        idle(1);
        budget--;
      end
      if (budget == 0) begin
        checks++; errors++;
        $display("FAIL t6 emit start: got %0d beats, required 3", got_q.size());
      end
    end
    rst_n = 1'b0;
    #1;
    chk("t6 reset valid", 134'(o_pkt_valid), 134'd0);
    chk("t6 reset pkt", o_pkt, 134'd0);
    exp_q.delete(); mp_q.delete(); ms_q.delete();
    err_m = 2'b00;
    idle(2);
    rst_n = 1'b1;
    idle(10);
    chk("t6 beats before reset", 134'(got_q.size()), 134'd3);
    chk("t6 err", 134'(o_err), 134'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
